// File: rtl/axis_event_buffer.sv
// Drop-on-full FWFT buffer between the window accumulator and an AXI4-Stream consumer.
// Reports occupancy, a high-watermark and a saturating drop count.
module axis_event_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4,
    parameter int CNTR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cfg_clear,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   sts_count,
    output logic [ADDR_WIDTH:0]   sts_peak,
    output logic [CNTR_WIDTH-1:0] sts_drops
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   count_nxt, peak_nxt;
    logic [CNTR_WIDTH-1:0] drops_nxt;
    logic                  tvalid_q;
    logic                  full, pop, push, drop;

    assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // A pop frees the slot at this edge, so a full buffer can still take a word.
    assign pop  = tvalid_q & m_axis_tready;
    assign push = s_axis_tvalid & (~full | pop);
    assign drop = s_axis_tvalid & full & ~pop;

    always_comb begin
        wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
        rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;

        count_nxt = sts_count;
        if (push && !pop)
            count_nxt = sts_count + PTR_ONE;
        else if (pop && !push)
            count_nxt = sts_count - PTR_ONE;

        if (cfg_clear)
            peak_nxt = count_nxt;
        else
            peak_nxt = (count_nxt > sts_peak) ? count_nxt : sts_peak;

        // A drop coinciding with a clear is counted as the first drop after it.
        drops_nxt = sts_drops;
        if (cfg_clear)
            drops_nxt = drop ? CNTR_ONE : '0;
        else if (drop && !(&sts_drops))
            drops_nxt = sts_drops + CNTR_ONE;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sts_count <= '0;
            sts_peak  <= '0;
            sts_drops <= '0;
            tvalid_q  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            sts_count <= count_nxt;
            sts_peak  <= peak_nxt;
            sts_drops <= drops_nxt;
            tvalid_q  <= (wr_ptr_nxt != rd_ptr_nxt);
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge aclk) begin
        if (push && !areset)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_tdata;
    end

    assign m_axis_tdata  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_event_buffer.sv
// Drives directed and random traffic into two buffers (full-width and 2-bit drop counter)
// and compares every cycle against a queue-based reference model.
module tb_axis_event_buffer;

    localparam int DW    = 128;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          aclk = 1'b0;
    logic          areset, cfg_clear, s_axis_tvalid, m_axis_tready;
    logic [DW-1:0] s_axis_tdata;

    logic [DW-1:0] m_axis_tdata,  m_axis_tdata_s;
    logic          m_axis_tvalid, m_axis_tvalid_s;
    logic [AW:0]   sts_count, sts_count_s, sts_peak, sts_peak_s;
    logic [31:0]   sts_drops;
    logic [1:0]    sts_drops_s;

    always #5 aclk = ~aclk;

    axis_event_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNTR_WIDTH(32)) u_dut (
        .aclk(aclk), .areset(areset), .cfg_clear(cfg_clear),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .sts_count(sts_count), .sts_peak(sts_peak), .sts_drops(sts_drops)
    );

    axis_event_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNTR_WIDTH(2)) u_dut_sat (
        .aclk(aclk), .areset(areset), .cfg_clear(cfg_clear),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata(m_axis_tdata_s), .m_axis_tvalid(m_axis_tvalid_s), .m_axis_tready(m_axis_tready),
        .sts_count(sts_count_s), .sts_peak(sts_peak_s), .sts_drops(sts_drops_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [DW-1:0] q[$];
    int            m_peak;
    longint        m_drops;
    int            m_drops_sat;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("tvalid", DW'(m_axis_tvalid), DW'(q.size() > 0));
        chk("count",  DW'(sts_count),     DW'(q.size()));
        chk("peak",   DW'(sts_peak),      DW'(m_peak));
        chk("drops",  DW'(sts_drops),     DW'(m_drops));
        chk("drops_sat", DW'(sts_drops_s), DW'(m_drops_sat));
        chk("tvalid_s", DW'(m_axis_tvalid_s), DW'(q.size() > 0));
        if (q.size() > 0) begin
            chk("tdata",   m_axis_tdata,   q[0]);
            chk("tdata_s", m_axis_tdata_s, q[0]);
        end
    endtask

    // Checks the state left by the previous edge, drives the next inputs and
    // advances the model to what the coming edge should produce.
    task automatic step(input logic rst, input logic clr, input logic vld,
                        input logic [DW-1:0] data, input logic rdy);
        bit pop, full, push, drop;
        @(negedge aclk);
        check_all();
        areset = rst; cfg_clear = clr; s_axis_tvalid = vld;
        s_axis_tdata = data; m_axis_tready = rdy;
        if (rst) begin
            q.delete(); m_peak = 0; m_drops = 0; m_drops_sat = 0;
            return;
        end
        full = (q.size() == DEPTH);
        pop  = (q.size() > 0) && rdy;
        push = vld && (!full || pop);
        drop = vld && full && !pop;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(data);
        if (clr) begin
            m_drops     = drop ? 1 : 0;
            m_drops_sat = drop ? 1 : 0;
            m_peak      = q.size();
        end else begin
            if (drop && m_drops < 64'hFFFF_FFFF) m_drops++;
            if (drop && m_drops_sat < 3) m_drops_sat++;
            if (q.size() > m_peak) m_peak = q.size();
        end
    endtask

    task automatic after_edge();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        areset = 1'b1; cfg_clear = 1'b0; s_axis_tvalid = 1'b0;
        s_axis_tdata = '0; m_axis_tready = 1'b0;
        q.delete(); m_peak = 0; m_drops = 0; m_drops_sat = 0;
        repeat (3) @(posedge aclk);

        // idle after reset with tready high
        for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 1);

        // five words held, then released
        for (int i = 1; i <= 5; i++) step(0, 0, 1, DW'(i), 0);
        for (int i = 0; i < 7; i++)  step(0, 0, 0, '0, 1);
        after_edge();
        chk("peak5", DW'(sts_peak), DW'(5));

        // overflow: 20 words into 16 slots
        for (int i = 100; i < 120; i++) step(0, 0, 1, DW'(i), 0);
        after_edge();
        chk("count16", DW'(sts_count), DW'(16));
        chk("drops4",  DW'(sts_drops), DW'(4));
        chk("sat3",    DW'(sts_drops_s), DW'(3));
        chk("head100", m_axis_tdata, DW'(100));
        for (int i = 0; i < 17; i++) step(0, 0, 0, '0, 1);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) step(0, 0, 1, DW'(200 + i), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, DW'(300 + i), 1);
        after_edge();
        chk("full_cont", DW'(sts_count), DW'(16));

        // drop coincident with clear, then a plain clear
        step(0, 1, 1, DW'(999), 0);
        after_edge();
        chk("clr_drop", DW'(sts_drops), DW'(1));
        chk("clr_peak", DW'(sts_peak),  DW'(16));
        step(0, 1, 0, '0, 0);
        after_edge();
        chk("clr_nodrop", DW'(sts_drops), DW'(0));
        for (int i = 0; i < 18; i++) step(0, 0, 0, '0, 1);

        // reset with words stored
        for (int i = 0; i < 7; i++) step(0, 0, 1, DW'(400 + i), 0);
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, DW'(8'hA5), 0);
        after_edge();
        chk("rst_head", m_axis_tdata, DW'(8'hA5));
        step(0, 0, 0, '0, 1);

        // randomized traffic with occasional clear and rare reset
        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode = i / 500;
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 99) < ((mode % 2 == 0) ? 80 : 40)),
                 rnd128(),
                 ($urandom_range(0, 99) < ((mode % 3 == 0) ? 30 : 70)));
        end
        step(0, 0, 0, '0, 1);
        @(negedge aclk);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
